// File: rtl/extbus_arbiter_if.sv
// Request/completion and external-bus pin bundle between the two internal
// requesters, the arbiter, and the board-level latch/SRAM.
`timescale 1ns/1ps
interface extbus_arbiter_if;
  logic        req0_valid;
  logic        req0_we;
  logic [15:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid;
  logic        req1_we;
  logic [15:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        done0;
  logic        done1;
  logic [15:0] rd_data;
  logic [15:0] db_out;
  logic [15:0] db_in;
  logic        db_oeb;
  logic        ALE;
  logic        BDIR;
  logic        OEB;
  logic        WEB;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output db_in,
    input  done0, done1, rd_data,
    input  db_out, db_oeb, ALE, BDIR, OEB, WEB
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  db_in,
    output done0, done1, rd_data,
    output db_out, db_oeb, ALE, BDIR, OEB, WEB
  );
endinterface

// File: rtl/extbus_arbiter.sv
// Round-robin two-port arbiter and address/data cycle sequencer for the shared
// multiplexed 16-bit external bus; every bus pin comes straight from a flop.
`timescale 1ns/1ps
module extbus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            wb_clk_i,
  input  logic            rst,
  input  logic            hold,
  extbus_arbiter_if.slave bus
);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ale_q, ale_d;
  logic        bdir_q, bdir_d;
  logic        oeb_q, oeb_d;
  logic        web_q, web_d;
  logic        dboeb_q, dboeb_d;
  logic [15:0] dbout_q, dbout_d;
  logic [15:0] rddata_q, rddata_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        grant;
  logic        data_phase;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    ale_d      = 1'b0;
    bdir_d     = 1'b0;
    oeb_d      = 1'b1;
    web_d      = 1'b1;
    dboeb_d    = 1'b1;
    dbout_d    = dbout_q;
    rddata_d   = rddata_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    data_phase = 1'b0;
    // On a tie the port not served last wins; otherwise the lone requester.
    grant = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

    unique case (state_q)
      S_IDLE: begin
        if (!hold && (bus.req0_valid || bus.req1_valid)) begin
          port_d  = grant;
          last_d  = grant;
          we_d    = grant ? bus.req1_we    : bus.req0_we;
          wdata_d = grant ? bus.req1_wdata : bus.req0_wdata;
          dbout_d = grant ? bus.req1_addr  : bus.req0_addr;
          ale_d   = 1'b1;
          dboeb_d = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d      = WAIT_LOAD;
        data_phase = 1'b1;
        state_d    = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == 3'd0) begin
          if (!we_q) rddata_d = bus.db_in;
          // Writes keep driving wdata through END so it is stable across WEB rise.
          dboeb_d = ~we_q;
          done0_d = ~port_q;
          done1_d = port_q;
          state_d = S_END;
        end else begin
          cnt_d      = cnt_q - 3'd1;
          data_phase = 1'b1;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (data_phase) begin
      bdir_d  = ~we_q;
      oeb_d   = we_q;
      web_d   = ~we_q;
      dboeb_d = ~we_q;
      if (we_q) dbout_d = wdata_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= 16'h0000;
      cnt_q    <= 3'd0;
      ale_q    <= 1'b0;
      bdir_q   <= 1'b0;
      oeb_q    <= 1'b1;
      web_q    <= 1'b1;
      dboeb_q  <= 1'b1;
      dbout_q  <= 16'h0000;
      rddata_q <= 16'h0000;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ale_q    <= ale_d;
      bdir_q   <= bdir_d;
      oeb_q    <= oeb_d;
      web_q    <= web_d;
      dboeb_q  <= dboeb_d;
      dbout_q  <= dbout_d;
      rddata_q <= rddata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign bus.ALE     = ale_q;
  assign bus.BDIR    = bdir_q;
  assign bus.OEB     = oeb_q;
  assign bus.WEB     = web_q;
  assign bus.db_oeb  = dboeb_q;
  assign bus.db_out  = dbout_q;
  assign bus.rd_data = rddata_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
endmodule

// File: tb/tb_extbus_arbiter.sv
// Bench for extbus_arbiter: three instances (WAIT_STATES 1, 0, 7) each with a
// latch+SRAM model on its bus, driven by directed and random requesters.
`timescale 1ns/1ps
module tb_extbus_arbiter;
  localparam int NDUT = 3;
  localparam int WS [NDUT] = '{1, 0, 7};

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]            rst;
  logic [NDUT-1:0]            hold;
  logic [NDUT-1:0][1:0]       v;
  logic [NDUT-1:0][1:0]       we;
  logic [NDUT-1:0][1:0][15:0] addr;
  logic [NDUT-1:0][1:0][15:0] wdata;
  wire  [NDUT-1:0][1:0]       done;
  wire  [NDUT-1:0][15:0]      rdd;
  wire  [NDUT-1:0][15:0]      dbo;
  wire  [NDUT-1:0]            dboeb, ale, bdir, oeb, web;

  logic [15:0] mem     [NDUT][65536];
  logic [15:0] ref_mem [NDUT][65536];
  logic [15:0] lat     [NDUT];

  for (genvar i = 0; i < NDUT; i++) begin : g
    extbus_arbiter_if bus ();
    assign bus.req0_valid = v[i][0];
    assign bus.req0_we    = we[i][0];
    assign bus.req0_addr  = addr[i][0];
    assign bus.req0_wdata = wdata[i][0];
    assign bus.req1_valid = v[i][1];
    assign bus.req1_we    = we[i][1];
    assign bus.req1_addr  = addr[i][1];
    assign bus.req1_wdata = wdata[i][1];
    assign bus.db_in      = (bus.BDIR && !bus.OEB) ? mem[i][lat[i]] : 16'hDEAD;
    assign done[i]  = {bus.done1, bus.done0};
    assign rdd[i]   = bus.rd_data;
    assign dbo[i]   = bus.db_out;
    assign dboeb[i] = bus.db_oeb;
    assign ale[i]   = bus.ALE;
    assign bdir[i]  = bus.BDIR;
    assign oeb[i]   = bus.OEB;
    assign web[i]   = bus.WEB;

    extbus_arbiter #(.WAIT_STATES(WS[i])) u_dut (
      .wb_clk_i (clk),
      .rst      (rst[i]),
      .hold     (hold[i]),
      .bus      (bus)
    );

    always @(negedge clk) begin
      if (bus.ALE) lat[i] <= bus.db_out;
      if (!bus.WEB) mem[i][lat[i]] <= bus.db_out;
    end
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int k, W, c;
  int busy_until, grant_cyc;
  bit last, gport, gwe, rand_mode;
  logic [15:0] gaddr, gwdata, gval, exp_rd;
  txn_t plan [2][$];
  int order_q [$];
  int done_c [$];
  int grant_q [$];
  int oeb_low, web_low, ale_cnt, both_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d dut %0d)", tag, obs, exp, c, k);
    end
  endtask

  function automatic txn_t mk(input bit w, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we = w;
    t.addr = a;
    t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), 16'h0400 + 16'(2 * $urandom_range(0, 7)), 16'($urandom));
  endfunction

  task automatic advance();
    @(negedge clk);
    c++;
  endtask

  // Expected pin levels derived from the cycle offset relative to the grant edge.
  task automatic check_outputs();
    int ph;
    logic e_ale, e_bdir, e_oeb, e_web, e_dboeb;
    logic [1:0] e_done;
    ph = c - grant_cyc;
    e_ale = 1'b0; e_bdir = 1'b0; e_oeb = 1'b1; e_web = 1'b1; e_dboeb = 1'b1; e_done = 2'b00;
    if (ph == 1) begin
      e_ale = 1'b1;
      e_dboeb = 1'b0;
      chk("db_out_addr", dbo[k], gaddr);
    end else if (ph >= 2 && ph <= 2 + W) begin
      if (gwe) begin
        e_web = 1'b0;
        e_dboeb = 1'b0;
        chk("db_out_wdata", dbo[k], gwdata);
      end else begin
        e_bdir = 1'b1;
        e_oeb = 1'b0;
      end
    end else if (ph == 3 + W) begin
      e_done = gport ? 2'b10 : 2'b01;
      if (gwe) begin
        e_dboeb = 1'b0;
        chk("db_out_end", dbo[k], gwdata);
      end else begin
        exp_rd = gval;
      end
    end
    chk("ALE", ale[k], e_ale);
    chk("BDIR", bdir[k], e_bdir);
    chk("OEB", oeb[k], e_oeb);
    chk("WEB", web[k], e_web);
    chk("db_oeb", dboeb[k], e_dboeb);
    chk("done", done[k], e_done);
    chk("rd_data", rdd[k], exp_rd);
    if (done[k] == 2'b01) order_q.push_back(0);
    if (done[k] == 2'b10) order_q.push_back(1);
    if (done[k] == 2'b11) both_done++;
    if (done[k] != 2'b00) done_c.push_back(c);
    if (!oeb[k]) oeb_low++;
    if (!web[k]) web_low++;
    if (ale[k]) ale_cnt++;
  endtask

  task automatic update_reqs();
    for (int p = 0; p < 2; p++) begin
      if (c == grant_cyc + 3 + W && int'(gport) == p) begin
        v[k][p] = 1'b0;
        if (plan[p].size() > 0) plan[p].delete(0);
      end
      if (!v[k][p] && plan[p].size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
        v[k][p]     = 1'b1;
        we[k][p]    = plan[p][0].we;
        addr[k][p]  = plan[p][0].addr;
        wdata[k][p] = plan[p][0].wdata;
      end
    end
    if (rand_mode) hold[k] = ($urandom_range(0, 7) == 0);
  endtask

  task automatic model_grant();
    if (c >= busy_until && !hold[k] && v[k] != 2'b00) begin
      gport  = (v[k] == 2'b11) ? ~last : v[k][1];
      last   = gport;
      gwe    = we[k][gport];
      gaddr  = addr[k][gport];
      gwdata = wdata[k][gport];
      grant_cyc  = c;
      busy_until = c + 4 + W;
      grant_q.push_back(c);
      if (gwe) ref_mem[k][gaddr] = gwdata;
      else     gval = ref_mem[k][gaddr];
    end
  endtask

  task automatic tick();
    check_outputs();
    update_reqs();
    model_grant();
    advance();
  endtask

  task automatic check_reset_vals(input int kk);
    chk("rst_ALE", ale[kk], 1'b0);
    chk("rst_BDIR", bdir[kk], 1'b0);
    chk("rst_OEB", oeb[kk], 1'b1);
    chk("rst_WEB", web[kk], 1'b1);
    chk("rst_db_oeb", dboeb[kk], 1'b1);
    chk("rst_db_out", dbo[kk], 16'h0000);
    chk("rst_done", done[kk], 2'b00);
    chk("rst_rd_data", rdd[kk], 16'h0000);
  endtask

  task automatic do_reset(input bit pre_check);
    if (pre_check) check_outputs();
    rst[k] = 1'b1;
    advance();
    check_reset_vals(k);
    rst[k] = 1'b0;
    last = 1'b1;
    grant_cyc = -1000;
    busy_until = c;
    exp_rd = 16'h0000;
    model_grant();
    advance();
  endtask

  task automatic begin_dut(input int kk);
    k = kk;
    W = WS[kk];
    v[k] = 2'b00;
    hold[k] = 1'b0;
    rand_mode = 1'b0;
    plan[0].delete();
    plan[1].delete();
    do_reset(1'b0);
    order_q.delete();
    done_c.delete();
    grant_q.delete();
    oeb_low = 0; web_low = 0; ale_cnt = 0; both_done = 0;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((plan[0].size() > 0 || plan[1].size() > 0 || c < busy_until) && n < budget) begin
      tick();
      n++;
    end
    chk("run_within_budget", (plan[0].size() == 0 && plan[1].size() == 0 && c >= busy_until), 1'b1);
  endtask

  task automatic tick_to_data(input int budget);
    int n;
    n = 0;
    while (c != grant_cyc + 2 && n < budget) begin
      tick();
      n++;
    end
    chk("reach_data_phase", (c == grant_cyc + 2), 1'b1);
  endtask

  initial begin
    rst = '1; hold = '0; v = '0; we = '0; addr = '0; wdata = '0;
    c = 0; k = 0; W = WS[0]; last = 1'b1; grant_cyc = -1000; busy_until = 0;
    gport = 1'b0; gwe = 1'b0; gaddr = '0; gwdata = '0; gval = '0; exp_rd = '0; rand_mode = 1'b0;
    oeb_low = 0; web_low = 0; ale_cnt = 0; both_done = 0;
    for (int d = 0; d < NDUT; d++) begin
      lat[d] = 16'h0000;
      for (int a = 0; a < 65536; a++) begin
        mem[d][a]     = 16'(a) ^ 16'h5A5A;
        ref_mem[d][a] = 16'(a) ^ 16'h5A5A;
      end
    end
    repeat (3) advance();
    for (int d = 0; d < NDUT; d++) begin
      k = d;
      check_reset_vals(d);
    end
    rst = '0;

    // Single read, W=1
    mem[0][16'h0100] = 16'hBEEF;
    ref_mem[0][16'h0100] = 16'hBEEF;
    begin_dut(0);
    plan[0].push_back(mk(1'b0, 16'h0100, 16'h0000));
    run(50);
    chk("t1_oeb_low_cycles", oeb_low, 2);
    chk("t1_rd_data", rdd[0], 16'hBEEF);
    chk("t1_done_count", order_q.size(), 1);
    if (order_q.size() == 1 && done_c.size() == 1 && grant_q.size() == 1) begin
      chk("t1_done_port", order_q[0], 0);
      chk("t1_latency", done_c[0] - grant_q[0], 4);
    end

    // Single write, W=0
    begin_dut(1);
    plan[1].push_back(mk(1'b1, 16'h2000, 16'h1234));
    run(50);
    chk("t2_web_low_cycles", web_low, 1);
    chk("t2_mem_2000", mem[1][16'h2000], 16'h1234);
    chk("t2_done_count", order_q.size(), 1);
    if (order_q.size() == 1) chk("t2_done_port", order_q[0], 1);

    // Contention: both ports continuously valid
    begin_dut(0);
    for (int j = 0; j < 3; j++) begin
      plan[0].push_back(rnd_txn());
      plan[1].push_back(rnd_txn());
    end
    run(200);
    chk("t3_done_count", order_q.size(), 6);
    chk("t3_both_done", both_done, 0);
    for (int j = 0; j < order_q.size(); j++) chk("t3_grant_order", order_q[j], j % 2);

    // hold keeps the bus idle; hold raised mid-transaction does not abort it
    begin_dut(0);
    hold[0] = 1'b1;
    plan[0].push_back(mk(1'b0, 16'h0102, 16'h0000));
    repeat (20) tick();
    chk("t4_hold_ale_cycles", ale_cnt, 0);
    chk("t4_hold_done_count", order_q.size(), 0);
    hold[0] = 1'b0;
    tick_to_data(10);
    hold[0] = 1'b1;
    run(50);
    chk("t4_completes_under_hold", order_q.size(), 1);
    hold[0] = 1'b0;

    // Reset during the DATA phase of a write, then re-grant
    begin_dut(0);
    plan[0].push_back(mk(1'b1, 16'h0300, 16'hA5A5));
    tick_to_data(10);
    do_reset(1'b1);
    run(50);
    chk("t5_done_count", order_q.size(), 1);
    chk("t5_mem_0300", mem[0][16'h0300], 16'hA5A5);
    chk("t5_both_done", both_done, 0);

    // WAIT_STATES=7, back-to-back reads on port 0
    begin_dut(2);
    for (int j = 0; j < 3; j++) plan[0].push_back(mk(1'b0, 16'h0600 + 16'(2 * j), 16'h0000));
    run(200);
    chk("t6_oeb_low_cycles", oeb_low, 24);
    chk("t6_done_count", done_c.size(), 3);
    if (done_c.size() == 3 && grant_q.size() == 3) begin
      chk("t6_latency", done_c[0] - grant_q[0], 10);
      chk("t6_spacing_a", done_c[1] - done_c[0], 11);
      chk("t6_spacing_b", done_c[2] - done_c[1], 11);
    end

    // Random traffic with random hold and random requester gaps
    begin_dut(0);
    rand_mode = 1'b1;
    for (int j = 0; j < 30; j++) begin
      plan[0].push_back(rnd_txn());
      plan[1].push_back(rnd_txn());
    end
    run(3000);
    rand_mode = 1'b0;
    hold[0] = 1'b0;
    chk("t7_done_count", order_q.size(), 60);
    chk("t7_both_done", both_done, 0);
    for (int j = 0; j < 8; j++)
      chk("t7_mem_final", mem[0][16'h0400 + 16'(2 * j)], ref_mem[0][16'h0400 + 16'(2 * j)]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
